inst_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the multicycle CPU core. It drives the core's 32-bit instruction input and reads the instruction memory over a req/ack handshake with variable latency. It holds one fetched word in a single-entry buffer so that a repeated fetch of the same address takes one cycle. Misaligned addresses, out-of-range addresses and memory timeouts return a NOP and raise a fault pulse.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 26 ++
 rtl/inst_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   INST_W    : instruction width
//   NOP_INST  : word substituted for an instruction that could not be fetched
//   fetch_state_e : fetch controller state encoding
package cpu_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the fetch unit.
//   clk, rst : clock, synchronous active-high reset
//   clr      : load zero (takes priority over en)
//   en       : increment by one
//   expired  : count == LIMIT
module fetch_timeout_ctr #(
    parameter logic [7:0] LIMIT = 8'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst)      count <= 8'd0;
        else if (clr) count <= 8'd0;
        else if (en)  count <= count + 8'd1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage in front of the multicycle core.
// Fetches one word from instruction memory over a req/ack handshake and keeps
// the last fetched word in a single-entry buffer, so an immediate refetch of
// the same PC answers in one cycle. Bad addresses and memory timeouts answer
// with NOP_INST and a fault pulse.
//   clk, rst              : clock, synchronous active-high reset
//   fetch_req, fetch_addr : request from the core (byte address), taken in IDLE
//   flush                 : invalidate the buffer
//   inst, inst_valid      : registered response word and its one-cycle strobe
//   fault                 : response is a NOP caused by an error
//   busy                  : memory access outstanding
//   mem_req, mem_addr     : memory request and word address
//   mem_ack, mem_rdata    : memory response
module inst_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              fault,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    import cpu_pkg::*;

    // The counter reads k during the (k+1)-th WAIT cycle, so comparing against
    // TIMEOUT-1 aborts at the end of the TIMEOUT-th cycle: mem_req is high for
    // exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);

    fetch_state_e        state_q, state_d;
    logic [INST_W-1:0]   inst_d;
    logic                inst_valid_d, fault_d;
    logic [ADDR_W-1:0]   mem_addr_d;

    // single-entry buffer
    logic                buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
    logic [INST_W-1:0]   buf_data_q, buf_data_d;
    // set by a flush seen during WAIT: the response must not be buffered
    logic                nocache_q, nocache_d;

    logic                ctr_clr, ctr_en, expired;
    logic [ADDR_W-1:0]   word_addr;
    logic                bad_addr, hit;

    assign word_addr = fetch_addr[ADDR_W+1:2];
    assign bad_addr  = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_W + 2)) != 32'd0);
    assign hit       = buf_valid_q && (buf_tag_q == word_addr) && !flush;

    assign mem_req = (state_q == WAIT);
    assign busy    = (state_q == WAIT);

    fetch_timeout_ctr #(.LIMIT(TO_LIMIT)) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inst        <= NOP_INST;
            inst_valid  <= 1'b0;
            fault       <= 1'b0;
            mem_addr    <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            nocache_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst        <= inst_d;
            inst_valid  <= inst_valid_d;
            fault       <= fault_d;
            mem_addr    <= mem_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            nocache_q   <= nocache_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_d       = inst;
        inst_valid_d = 1'b0;
        fault_d      = 1'b0;
        mem_addr_d   = mem_addr;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
        nocache_d    = nocache_q;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                // A request in the response cycle is dropped: the core has not
                // yet seen the previous answer.
                if (fetch_req && !inst_valid) begin
                    if (bad_addr) begin
                        inst_d       = NOP_INST;
                        inst_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (hit) begin
                        inst_d       = buf_data_q;
                        inst_valid_d = 1'b1;
                    end else begin
                        mem_addr_d = word_addr;
                        ctr_clr    = 1'b1;
                        nocache_d  = 1'b0;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                ctr_en = 1'b1;
                if (flush) nocache_d = 1'b1;
                // ack wins over a simultaneous timeout
                if (mem_ack) begin
                    inst_d       = mem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = IDLE;
                    if (!(nocache_q || flush)) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = mem_addr;
                        buf_data_d  = mem_rdata;
                    end
                end else if (expired) begin
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b1;
                    fault_d      = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // no buffer load above happens with flush high, so this is safe last
        if (flush) buf_valid_d = 1'b0;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic        busy;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int mreq_cnt = 0;   // clock edges seen with mem_req high
    int iv_cnt   = 0;   // inst_valid pulses seen

    inst_fetch_unit #(.ADDR_W(10), .TIMEOUT(16), .NOP_INST(32'h0000_0013)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fault      (fault),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req)    mreq_cnt++;
        if (inst_valid) iv_cnt++;
    end

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_iv(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int m0, v0;
        bit seen;

        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_inst", inst, NOP);
        chk("rst_iv", {31'd0, inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mreq", {31'd0, mem_req}, 32'd0);
        chk("rst_maddr", {22'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        step();

        // miss to 0x8, ack 3 cycles after mem_req rises
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        fetch_req = 1'b0;
        chk("t1_mreq", {31'd0, mem_req}, 32'd1);
        chk("t1_maddr", {22'd0, mem_addr}, 32'd2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step(); step(); step();
        chk("t1_iv_early", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        mem_ack = 1'b0;
        chk("t1_iv", {31'd0, inst_valid}, 32'd1);
        chk("t1_inst", inst, 32'h0050_0093);
        chk("t1_fault", {31'd0, fault}, 32'd0);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        step();
        chk("t1_iv_pulse", {31'd0, inst_valid}, 32'd0);

        // hit on 0x8
        m0 = mreq_cnt;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        fetch_req = 1'b0;
        chk("t2_iv", {31'd0, inst_valid}, 32'd1);
        chk("t2_inst", inst, 32'h0050_0093);
        chk("t2_fault", {31'd0, fault}, 32'd0);
        step();
        chk("t2_no_mreq", mreq_cnt - m0, 32'd0);

        // misaligned, then out of range
        m0 = mreq_cnt;
        fetch_req = 1'b1; fetch_addr = 32'h6;
        step();
        fetch_req = 1'b0;
        chk("t3_mis_iv", {31'd0, inst_valid}, 32'd1);
        chk("t3_mis_inst", inst, NOP);
        chk("t3_mis_fault", {31'd0, fault}, 32'd1);
        step();
        fetch_req = 1'b1; fetch_addr = 32'h1000;
        step();
        fetch_req = 1'b0;
        chk("t3_oor_iv", {31'd0, inst_valid}, 32'd1);
        chk("t3_oor_inst", inst, NOP);
        chk("t3_oor_fault", {31'd0, fault}, 32'd1);
        step();
        chk("t3_no_mreq", mreq_cnt - m0, 32'd0);

        // timeout on 0xC
        m0 = mreq_cnt;
        fetch_req = 1'b1; fetch_addr = 32'hC;
        step();
        fetch_req = 1'b0;
        wait_iv(40, seen);
        chk("t4_seen", {31'd0, seen}, 32'd1);
        chk("t4_inst", inst, NOP);
        chk("t4_fault", {31'd0, fault}, 32'd1);
        chk("t4_mreq_len", mreq_cnt - m0, 32'd16);
        chk("t4_mreq_low", {31'd0, mem_req}, 32'd0);
        step();
        // refetch must go to memory again; zero-wait ack
        fetch_req = 1'b1; fetch_addr = 32'hC;
        step();
        fetch_req = 1'b0;
        chk("t4_refetch_mreq", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        chk("t4_refetch_iv", {31'd0, inst_valid}, 32'd1);
        chk("t4_refetch_inst", inst, 32'h1234_5678);
        chk("t4_refetch_fault", {31'd0, fault}, 32'd0);
        step();

        // flush during WAIT: delivered but not buffered
        fetch_req = 1'b1; fetch_addr = 32'h10;
        step();
        fetch_req = 1'b0;
        chk("t5_mreq", {31'd0, mem_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
        step();
        mem_ack = 1'b0;
        chk("t5_iv", {31'd0, inst_valid}, 32'd1);
        chk("t5_inst", inst, 32'h00A0_0113);
        step();
        fetch_req = 1'b1; fetch_addr = 32'h10;
        step();
        fetch_req = 1'b0;
        chk("t5_refetch_miss", {31'd0, mem_req}, 32'd1);
        chk("t5_refetch_iv", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
        step();
        mem_ack = 1'b0;
        chk("t5_refill_iv", {31'd0, inst_valid}, 32'd1);
        step();
        // now buffered; flush in the lookup cycle forces a miss
        fetch_req = 1'b1; fetch_addr = 32'h10; flush = 1'b1;
        step();
        fetch_req = 1'b0; flush = 1'b0;
        chk("t5_flush_miss", {31'd0, mem_req}, 32'd1);
        chk("t5_flush_iv", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
        step();
        mem_ack = 1'b0;
        chk("t5_flush_resp", inst, 32'h00A0_0113);
        step();

        // reset during WAIT, fetch_req in WAIT, stray ack in IDLE
        v0 = iv_cnt;
        fetch_req = 1'b1; fetch_addr = 32'h14;
        step();
        fetch_addr = 32'h8;   // request held into WAIT: ignored
        step();
        fetch_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_mreq", {31'd0, mem_req}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_inst", inst, NOP);
        chk("t6_iv", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        step();
        chk("t6_no_resp", iv_cnt - v0, 32'd0);
        chk("t6_inst_hold", inst, NOP);
        // buffer was invalidated by reset: 0x8 misses
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        fetch_req = 1'b0;
        chk("t6_post_rst_miss", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        mem_ack = 1'b0;
        chk("t6_post_rst_inst", inst, 32'h0050_0093);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
